rtr_switch_allocator: RTL and testbench
=======================================

// Module: rtr_switch_allocator
// PURPOSE
//   Per-router wormhole switch allocator. Looks up each input's head-flit destination in the
//   routing table, grants each output port to one input by round-robin arbitration, and holds
//   that output locked to its owner until the owner's tail flit transfers. Its out_sel bus
//   drives the router crossbar mux, and its in_ready bus drives the input buffer pop.
// PARAMETERS
//   NUM_ROWS    2                          mesh rows
//   NUM_COLS    2                          mesh columns
//   NUM_PORTS   5                          ports: 0 local, 1 N, 2 S, 3 E, 4 W
//   NUM_NODES   NUM_ROWS*NUM_COLS          routing table entries
//   ROUTE_WIDTH $clog2(NUM_PORTS)          width of one table entry / port index
//   ADDR_WIDTH  $clog2(NUM_NODES)          destination address {row_id, col_id}
// PORTS
//   clk          in   1                       sole clock; all logic on posedge
//   reset        in   1                       synchronous, active-high
//   route_table  in   NUM_NODES*ROUTE_WIDTH   entry d at [d*ROUTE_WIDTH +: ROUTE_WIDTH]
//   in_valid     in   NUM_PORTS               input i presents a flit
//   in_head      in   NUM_PORTS               flit is a head
//   in_tail      in   NUM_PORTS               flit is a tail (head&tail = single-flit packet)
//   in_dest      in   NUM_PORTS*ADDR_WIDTH    destination; sampled only on head flits
//   in_ready     out  NUM_PORTS               input i flit accepted when in_valid&in_ready
//   out_ready    in   NUM_PORTS               downstream of output o can take a flit
//   out_valid    out  NUM_PORTS               flit on output o this cycle
//   out_sel      out  NUM_PORTS*ROUTE_WIDTH   owner input index of output o (crossbar select)
//   out_locked   out  NUM_PORTS               output o is owned by a packet
//   err          out  2                       sticky: [0] bad dest, [1] orphan body/tail flit
// BEHAVIOUR
//   - Requests: input i requests output route_table[in_dest[i]] only if in_valid&in_head and
//     i owns no output. in_dest >= NUM_NODES issues no request, sets err[0], and the flit stalls.
//   - Per-output FSM, IDLE / LOCKED(owner):
//     IDLE: if any requests exist, grant the first requester after ptr[o] in cyclic order.
//       Next cycle the output is LOCKED(owner). No flit moves in the arbitration cycle.
//       Allocation latency is therefore 1 cycle.
//     LOCKED: in_ready[owner] = out_ready[o]; out_valid[o] = in_valid[owner]; out_sel[o] = owner.
//       A transfer occurs when in_valid & out_ready.
//       A transfer with in_tail -> IDLE next cycle, and ptr[o] <= owner.
//       Stalls of any length keep the lock.
//   - Outputs not LOCKED: out_valid=0, out_sel=0, out_locked=0.
//   - Inputs not owning a LOCKED output: in_ready=0.
//   - Several outputs may arbitrate in the same cycle. An input requests only one output, so
//     no input gets two grants.
//   - Tail transfer and a new request for the same output in the same cycle: the new request is
//     arbitrated in the following (IDLE) cycle. A packet therefore costs payload + 1 cycles.
//   - A non-head flit valid at an input that owns no output: err[1] set, in_ready stays 0.
//   - err bits clear only on reset.
//   - Reset (any cycle, including mid-packet): all outputs IDLE, ptr[o] = NUM_PORTS-1 (input 0
//     has first priority), in_ready=0, out_valid=0, out_sel=0, out_locked=0, err=0.
//     Partially sent packets are abandoned. Clearing flits is the input buffers' job.
//   - U-turns are not excluded: the allocator honours whatever the routing table returns.
// TESTING
//   - Single-flit, 2x2 mesh, router 0 table {0,3,2,2}. Input 0 head+tail with dest=1:
//     output 3 locks at cycle 1, transfers at cycle 1, returns to IDLE at cycle 2.
//   - Contention: inputs 1, 2 and 4 send 3-flit packets to output 0 simultaneously.
//     Grants go in order 1, 2, 4. Each packet is 3 contiguous flits on out_sel; total 12 cycles.
//   - Back-pressure: out_ready=0 for 5 cycles mid-packet. Lock holds, no flit is lost or
//     duplicated, and out_valid stays high while in_valid is high.
//   - Parallel: input 1 sends to E and input 3 sends to local in the same cycle. Both lock in
//     the same cycle and stream concurrently with no interference.
//   - Errors: dest=7 with NUM_NODES=4 sets err[0] and the flit stalls. A body flit on an
//     unowned input sets err[1].
//   - Reset asserted on flit 2 of a 4-flit packet: next cycle all out_locked=0, in_ready=0,
//     err=0. The first post-reset grant goes to the lowest-index requester.

Source files
------------

// File: rtl/rtr_switch_allocator_if.sv
// rtr_switch_allocator_if: flit handshake and crossbar-select bundle between input buffers, allocator and crossbar.
interface rtr_switch_allocator_if #(
    parameter int NUM_PORTS   = 5,
    parameter int ADDR_WIDTH  = 2,
    parameter int ROUTE_WIDTH = 3
);
    logic [NUM_PORTS-1:0]             in_valid, in_head, in_tail, in_ready;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_dest;
    logic [NUM_PORTS-1:0]             out_ready, out_valid, out_locked;
    logic [NUM_PORTS*ROUTE_WIDTH-1:0] out_sel;
    modport master (
        output in_valid, in_head, in_tail, in_dest, out_ready,
        input  in_ready, out_valid, out_sel, out_locked
    );
    modport slave (
        input  in_valid, in_head, in_tail, in_dest, out_ready,
        output in_ready, out_valid, out_sel, out_locked
    );
endinterface

// File: rtl/rtr_switch_allocator.sv
// rtr_switch_allocator: wormhole switch allocator with table routing, per-output round-robin grant and packet lock.
module rtr_switch_allocator #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int NUM_PORTS   = 5,
    parameter int NUM_NODES   = NUM_ROWS * NUM_COLS,
    parameter int ROUTE_WIDTH = $clog2(NUM_PORTS),
    parameter int ADDR_WIDTH  = $clog2(NUM_NODES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_NODES*ROUTE_WIDTH-1:0] route_table,
    rtr_switch_allocator_if.slave            sw,
    output logic [1:0]                       err
);
    typedef enum logic {IDLE, LOCKED} state_t;
    typedef logic [ROUTE_WIDTH-1:0] idx_t;

    state_t state [NUM_PORTS];
    state_t state_nx [NUM_PORTS];
    idx_t owner [NUM_PORTS];
    idx_t owner_nx [NUM_PORTS];
    idx_t ptr [NUM_PORTS];
    idx_t ptr_nx [NUM_PORTS];
    idx_t route [NUM_PORTS];
    logic [NUM_PORTS-1:0] owns, req_ok;
    logic [1:0] err_nx;
    logic found, bad_dest;
    int idx;

    always_comb begin
        owns = '0;
        sw.in_ready = '0;
        sw.out_valid = '0;
        sw.out_sel = '0;
        sw.out_locked = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            if (state[o] == LOCKED) begin
                owns[owner[o]] = 1'b1;
                sw.in_ready[owner[o]] = sw.out_ready[o];
                sw.out_valid[o] = sw.in_valid[owner[o]];
                sw.out_sel[o*ROUTE_WIDTH +: ROUTE_WIDTH] = owner[o];
                sw.out_locked[o] = 1'b1;
            end
        err_nx = err;
        bad_dest = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            route[i] = '0;
            for (int d = 0; d < NUM_NODES; d++)
                if (int'(sw.in_dest[i*ADDR_WIDTH +: ADDR_WIDTH]) == d)
                    route[i] = route_table[d*ROUTE_WIDTH +: ROUTE_WIDTH];
            bad_dest = int'(sw.in_dest[i*ADDR_WIDTH +: ADDR_WIDTH]) >= NUM_NODES;
            // Only unowned inputs arbitrate; an owner's flits flow through its lock instead
            req_ok[i] = sw.in_valid[i] & sw.in_head[i] & ~owns[i] & ~bad_dest;
            err_nx[0] = err_nx[0] | (sw.in_valid[i] & sw.in_head[i] & ~owns[i] & bad_dest);
            err_nx[1] = err_nx[1] | (sw.in_valid[i] & ~sw.in_head[i] & ~owns[i]);
        end
    end

    always_comb begin
        found = 1'b0;
        idx = 0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_nx[o] = state[o];
            owner_nx[o] = owner[o];
            ptr_nx[o] = ptr[o];
            if (state[o] == LOCKED) begin
                if (sw.in_valid[owner[o]] & sw.out_ready[o] & sw.in_tail[owner[o]]) begin
                    state_nx[o] = IDLE;
                    ptr_nx[o] = owner[o];
                end
            end else begin
                found = 1'b0;
                // Scan cyclically starting just after the last owner
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    idx = (int'(ptr[o]) + k) % NUM_PORTS;
                    if (!found && req_ok[idx] && route[idx] == idx_t'(o)) begin
                        found = 1'b1;
                        state_nx[o] = LOCKED;
                        owner_nx[o] = idx_t'(idx);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                ptr[o] <= idx_t'(NUM_PORTS - 1);
            end
            err <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr <= ptr_nx;
            err <= err_nx;
        end
endmodule

// File: tb/tb_rtr_switch_allocator.sv
// tb_rtr_switch_allocator: queue-fed flit sources against a per-output ownership model of the allocator.
module tb_rtr_switch_allocator;
    localparam int NP = 5, AW = 3, RW = 3, NN = 4;
    typedef struct {bit h; bit t; int d;} flit_t;

    logic clk = 1'b0;
    logic reset;
    logic [NN*RW-1:0] route_table;
    logic [1:0] err;

    rtr_switch_allocator_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .ROUTE_WIDTH(RW)) bus ();
    rtr_switch_allocator #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .route_table(route_table), .sw(bus), .err(err)
    );

    always #5 clk = ~clk;

    flit_t q[NP][$];
    int own[NP], ptr[NP], tbl[NN], stall[NP], dut_xfer[NP];
    logic [1:0] m_err;
    int total = 0, bad = 0;
    int vprob = 100;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_table(int a, int b, int c, int d);
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
        for (int i = 0; i < NN; i++) route_table[i*RW +: RW] = RW'(tbl[i]);
    endtask

    task automatic push(int i, int len, int dest);
        for (int k = 0; k < len; k++) q[i].push_back('{h: k == 0, t: k == len - 1, d: dest});
    endtask

    task automatic clear_q();
        for (int i = 0; i < NP; i++) begin
            q[i].delete();
            stall[i] = 0;
            dut_xfer[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = '0; bus.in_head = '0; bus.in_tail = '0; bus.in_dest = '0; bus.out_ready = '0;
        clear_q();
        @(posedge clk);
        for (int o = 0; o < NP; o++) begin own[o] = -1; ptr[o] = NP - 1; end
        m_err = '0;
        #1 reset = 1'b0;
    endtask

    // One cycle: present queue fronts, compare against the model, clock, advance the model.
    task automatic step(logic [NP-1:0] ordy);
        logic [NP-1:0] v, h, t, erdy, eov, elk;
        logic [NP*RW-1:0] esel;
        logic [NP*AW-1:0] dv;
        int dd[NP], want[NP];
        bit owned, got;
        v = '0; h = '0; t = '0; dv = '0;
        for (int i = 0; i < NP; i++) begin
            dd[i] = 0;
            if (q[i].size() > 0 && $urandom_range(99) < vprob) begin
                v[i] = 1'b1; h[i] = q[i][0].h; t[i] = q[i][0].t; dd[i] = q[i][0].d;
                dv[i*AW +: AW] = AW'(dd[i]);
            end
        end
        bus.in_valid = v; bus.in_head = h; bus.in_tail = t; bus.in_dest = dv; bus.out_ready = ordy;
        erdy = '0; eov = '0; elk = '0; esel = '0;
        for (int o = 0; o < NP; o++)
            if (own[o] >= 0) begin
                elk[o] = 1'b1;
                esel[o*RW +: RW] = RW'(own[o]);
                eov[o] = v[own[o]];
                erdy[own[o]] = ordy[o];
            end
        #2;
        check("in_ready", 32'(bus.in_ready), 32'(erdy));
        check("out_valid", 32'(bus.out_valid), 32'(eov));
        check("out_sel", 32'(bus.out_sel), 32'(esel));
        check("out_locked", 32'(bus.out_locked), 32'(elk));
        check("err", 32'(err), 32'(m_err));
        for (int o = 0; o < NP; o++) if (bus.out_valid[o] && ordy[o]) dut_xfer[o]++;
        @(posedge clk);
        if (reset) begin
            for (int o = 0; o < NP; o++) begin own[o] = -1; ptr[o] = NP - 1; end
            m_err = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                want[i] = -1;
                owned = 0;
                for (int o = 0; o < NP; o++) if (own[o] == i) owned = 1;
                if (v[i] && !owned) begin
                    if (!h[i]) m_err[1] = 1'b1;
                    else if (dd[i] >= NN) m_err[0] = 1'b1;
                    else want[i] = tbl[dd[i]];
                end
            end
            for (int o = 0; o < NP; o++)
                if (own[o] < 0) begin
                    got = 0;
                    for (int k = 1; k <= NP; k++)
                        if (!got && want[(ptr[o] + k) % NP] == o) begin
                            got = 1;
                            own[o] = (ptr[o] + k) % NP;
                        end
                end else if (v[own[o]] && ordy[o] && t[own[o]]) begin
                    ptr[o] = own[o];
                    own[o] = -1;
                end
        end
        for (int i = 0; i < NP; i++) begin
            if (v[i] && erdy[i]) begin void'(q[i].pop_front()); stall[i] = 0; end
            else if (v[i]) stall[i]++;
            owned = 0;
            for (int o = 0; o < NP; o++) if (own[o] == i) owned = 1;
            // Give up on a flit that can never be accepted (bad dest, orphan, starved head)
            if (stall[i] > 40 && !owned) begin q[i].delete(); stall[i] = 0; end
        end
        #1;
    endtask

    task automatic run(int n, logic [NP-1:0] ordy);
        for (int c = 0; c < n; c++) step(ordy);
    endtask

    task automatic random_phase(int n);
        logic [NP-1:0] ordy;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (q[i].size() == 0 && $urandom_range(999) < 5)
                    q[i].push_back('{h: 1'b0, t: 1'($urandom_range(1)), d: 0});
                else if (q[i].size() == 0 && $urandom_range(99) < 25)
                    push(i, $urandom_range(4, 1),
                         $urandom_range(99) < 5 ? $urandom_range(7, 4) : $urandom_range(3));
                ordy[i] = $urandom_range(99) < 75;
            end
            step(ordy);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_table(0, 3, 2, 2);
        do_reset();
        run(2, '1);
        check("rst_locked", 32'(bus.out_locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        push(0, 1, 1);
        step('1);
        check("single_lock_c1", 32'(bus.out_locked), 32'b01000);
        run(2, '1);
        check("single_idle_c2", 32'(bus.out_locked), 32'd0);

        clear_q();
        push(1, 3, 0); push(2, 3, 0); push(4, 3, 0);
        run(12, '1);
        check("cont_xfers", 32'(dut_xfer[0]), 32'd9);
        check("cont_done", 32'(bus.out_locked), 32'd0);

        clear_q();
        push(0, 6, 2);
        run(3, '1);
        run(5, 5'b11011);
        check("bp_hold", 32'(bus.out_locked), 32'b00100);
        run(5, '1);
        check("bp_xfers", 32'(dut_xfer[2]), 32'd6);

        clear_q();
        push(1, 3, 1); push(3, 3, 0);
        step('1);
        check("par_lock", 32'(bus.out_locked), 32'b01001);
        run(4, '1);
        check("par_xfers", 32'(dut_xfer[3] + dut_xfer[0]), 32'd6);

        clear_q();
        push(0, 1, 7);
        run(3, '1);
        check("bad_dest_err", 32'(err), 32'b01);
        clear_q();
        q[2].push_back('{h: 1'b0, t: 1'b1, d: 0});
        run(2, '1);
        check("orphan_err", 32'(err), 32'b11);

        clear_q();
        push(3, 4, 2);
        run(2, '1);
        reset = 1'b1;
        step('1);
        reset = 1'b0;
        clear_q();
        check("mid_rst_locked", 32'(bus.out_locked), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        push(4, 1, 0); push(2, 1, 0);
        step('1);
        check("post_rst_grant", 32'(bus.out_sel[2:0]), 32'd2);
        run(4, '1);

        vprob = 85;
        random_phase(2500);
        set_table($urandom_range(4), $urandom_range(4), $urandom_range(4), $urandom_range(4));
        do_reset();
        random_phase(2500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
